// File: rtl/playfield_rotator.sv
`timescale 1ns/1ps
// playfield_rotator: CORDIC cos/sin from a latched spin angle (coef_done ITER+2 after update); pixels rotated with fixed 3-cycle latency, no backpressure.
// Optional ROTATOR_SCALE_EN adds a Q1.7 scale input, applied to the coefficients in an extra commit cycle.
module playfield_rotator #(
  parameter int ITER = 12,
  parameter int CW   = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           angle,
  input  logic                 update,
`ifdef ROTATOR_SCALE_EN
  input  logic [7:0]           scale,
`endif
  output logic                 busy,
  output logic                 coef_done,
  input  logic                 pix_valid,
  input  logic signed [CW-1:0] pix_x,
  input  logic signed [CW-1:0] pix_y,
  output logic                 out_valid,
  output logic signed [CW-1:0] rx,
  output logic signed [CW-1:0] ry
);
  localparam int CNTW = 4;
  localparam int PW   = CW + 16;
  localparam int SW   = CW + 17;

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t             state;
  logic [CNTW-1:0]    iter_cnt;
  logic [1:0]         quad;
  logic signed [17:0] cx, cy;
  logic signed [15:0] cz;
  logic signed [15:0] cos_c, sin_c;

  function automatic logic signed [15:0] atan_lut(input logic [CNTW-1:0] i);
    case (i)
      4'd0:    atan_lut = 16'sd8192;
      4'd1:    atan_lut = 16'sd4836;
      4'd2:    atan_lut = 16'sd2555;
      4'd3:    atan_lut = 16'sd1297;
      4'd4:    atan_lut = 16'sd651;
      4'd5:    atan_lut = 16'sd326;
      4'd6:    atan_lut = 16'sd163;
      4'd7:    atan_lut = 16'sd81;
      4'd8:    atan_lut = 16'sd41;
      4'd9:    atan_lut = 16'sd20;
      4'd10:   atan_lut = 16'sd10;
      4'd11:   atan_lut = 16'sd5;
      4'd12:   atan_lut = 16'sd3;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  logic signed [17:0] x_sh, y_sh;
  logic signed [15:0] at;
  logic               dir;
  logic signed [15:0] uc, us;

  always_comb begin
    x_sh = cx >>> iter_cnt;
    y_sh = cy >>> iter_cnt;
    at   = atan_lut(iter_cnt);
    dir  = ~cz[15];
  end

  // CORDIC only covers the first quadrant; the folded-off quadrant is restored here.
  always_comb begin
    uc = cx[15:0];
    us = cy[15:0];
    case (quad)
      2'd1:    begin uc = -cy[15:0]; us =  cx[15:0]; end
      2'd2:    begin uc = -cx[15:0]; us = -cy[15:0]; end
      2'd3:    begin uc =  cy[15:0]; us = -cx[15:0]; end
      default: ;
    endcase
  end

`ifdef ROTATOR_SCALE_EN
  logic [7:0]         scale_q;
  logic               commit_ph;
  logic signed [15:0] sc_c, sc_s;
  logic signed [22:0] prod_c, prod_s;
  assign prod_c = 23'(uc) * 23'($signed({1'b0, scale_q}));
  assign prod_s = 23'(us) * 23'($signed({1'b0, scale_q}));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      iter_cnt  <= '0;
      quad      <= '0;
      cx        <= '0;
      cy        <= '0;
      cz        <= '0;
      busy      <= 1'b0;
      coef_done <= 1'b0;
      cos_c     <= 16'sd16384;
      sin_c     <= 16'sd0;
`ifdef ROTATOR_SCALE_EN
      scale_q   <= 8'd128;
      commit_ph <= 1'b0;
      sc_c      <= '0;
      sc_s      <= '0;
`endif
    end else begin
      coef_done <= 1'b0;
      // A new update always wins, abandoning any run in progress.
      if (update) begin
        quad     <= angle[9:8];
        cz       <= {2'b00, angle[7:0], 6'b0};
        cx       <= 18'sd9949;
        cy       <= '0;
        iter_cnt <= '0;
        state    <= RUN;
        busy     <= 1'b1;
`ifdef ROTATOR_SCALE_EN
        scale_q   <= scale;
        commit_ph <= 1'b0;
`endif
      end else begin
        case (state)
          RUN: begin
            cx <= dir ? cx - y_sh : cx + y_sh;
            cy <= dir ? cy + x_sh : cy - x_sh;
            cz <= dir ? cz - at : cz + at;
            if (iter_cnt == CNTW'(ITER - 1)) state <= COMMIT;
            else iter_cnt <= iter_cnt + 1'b1;
          end
          COMMIT: begin
`ifdef ROTATOR_SCALE_EN
            if (!commit_ph) begin
              sc_c      <= 16'(prod_c >>> 7);
              sc_s      <= 16'(prod_s >>> 7);
              commit_ph <= 1'b1;
            end else begin
              cos_c     <= sc_c;
              sin_c     <= sc_s;
              coef_done <= 1'b1;
              busy      <= 1'b0;
              commit_ph <= 1'b0;
              state     <= IDLE;
            end
`else
            cos_c     <= uc;
            sin_c     <= us;
            coef_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
`endif
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic                 v1, v2;
  logic signed [CW-1:0] x1, y1;
  logic signed [PW-1:0] pxc, pys, pxs, pyc;
  logic signed [SW-1:0] sum_x, sum_y;

  function automatic logic signed [CW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1:CW-1] == '0 || v[SW-1:CW-1] == '1) sat = v[CW-1:0];
    else if (v[SW-1]) sat = {1'b1, {(CW-1){1'b0}}};
    else sat = {1'b0, {(CW-1){1'b1}}};
  endfunction

  always_comb begin
    sum_x = SW'(pxc) - SW'(pys);
    sum_y = SW'(pxs) + SW'(pyc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      y1        <= '0;
      pxc       <= '0;
      pys       <= '0;
      pxs       <= '0;
      pyc       <= '0;
      rx        <= '0;
      ry        <= '0;
    end else begin
      v1        <= pix_valid;
      v2        <= v1;
      out_valid <= v2;
      if (pix_valid) begin
        x1 <= pix_x;
        y1 <= pix_y;
      end
      // Coefficients are sampled here, so a commit switches between whole pixels.
      if (v1) begin
        pxc <= PW'(x1) * PW'(cos_c);
        pys <= PW'(y1) * PW'(sin_c);
        pxs <= PW'(x1) * PW'(sin_c);
        pyc <= PW'(y1) * PW'(cos_c);
      end
      if (v2) begin
        rx <= sat(sum_x >>> 14);
        ry <= sat(sum_y >>> 14);
      end
    end
  end
endmodule

// File: tb/tb_playfield_rotator.sv
`timescale 1ns/1ps
// Bench for playfield_rotator: vector table, hand-written restart/reset sequences,
// and random traffic checked against a trigonometric reference model.
module tb_playfield_rotator;
  localparam int ITER = 12;
  localparam int CW   = 11;
`ifdef ROTATOR_SCALE_EN
  localparam int DONE_LAT = ITER + 3;
`else
  localparam int DONE_LAT = ITER + 2;
`endif
  localparam int MAXC = 20000;
  localparam int RTOL = 3;
  localparam int PMAX = (1 << (CW - 1)) - 1;
  localparam int PMIN = -(1 << (CW - 1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [9:0]           angle = '0;
  logic                 update = 1'b0;
`ifdef ROTATOR_SCALE_EN
  logic [7:0]           scale = 8'd128;
`endif
  logic                 busy, coef_done;
  logic                 pix_valid = 1'b0;
  logic signed [CW-1:0] pix_x = '0;
  logic signed [CW-1:0] pix_y = '0;
  logic                 out_valid;
  logic signed [CW-1:0] rx, ry;

  playfield_rotator #(.ITER(ITER), .CW(CW)) dut (
    .clk(clk), .reset(reset), .angle(angle), .update(update),
`ifdef ROTATOR_SCALE_EN
    .scale(scale),
`endif
    .busy(busy), .coef_done(coef_done),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .out_valid(out_valid), .rx(rx), .ry(ry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int x; int y; int cyc; } pix_t;
  pix_t pq[$];
  real  hist_c[MAXC];
  real  hist_s[MAXC];
  bit   hist_id[MAXC];
  real  cur_c = 1.0, cur_s = 0.0;
  bit   cur_id = 1'b1;
  int   upd_cyc = -1;
  real  upd_c, upd_s;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  function automatic int rot_ref(input int x, input int y, input real c, input real s, input bit want_x);
    real v;
    int  e;
    v = want_x ? (real'(x) * c - real'(y) * s) : (real'(x) * s + real'(y) * c);
    e = $rtoi($floor(v));
    if (e > PMAX) e = PMAX;
    if (e < PMIN) e = PMIN;
    return e;
  endfunction

  // Records this cycle's inputs into the model, advances one clock, then checks outputs.
  task automatic tick();
    real  th, sc;
    pix_t p;
    int   exp_done, exp_busy, exp_v, tol;
    if (reset) begin
      pq.delete();
      upd_cyc = -1;
      cur_c = 1.0; cur_s = 0.0; cur_id = 1'b1;
    end else begin
      if (update) begin
        th = real'(angle) * 6.283185307179586 / 1024.0;
        sc = 1.0;
`ifdef ROTATOR_SCALE_EN
        sc = real'(scale) / 128.0;
`endif
        upd_cyc = cyc;
        upd_c = $cos(th) * sc;
        upd_s = $sin(th) * sc;
      end
      if (pix_valid) begin
        p.x = int'(pix_x); p.y = int'(pix_y); p.cyc = cyc;
        pq.push_back(p);
      end
    end
    @(negedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    exp_done = 0;
    exp_busy = 0;
    if (upd_cyc >= 0) begin
      if (cyc == upd_cyc + DONE_LAT) begin
        cur_c = upd_c; cur_s = upd_s; cur_id = 1'b0;
        upd_cyc = -1;
        exp_done = 1;
      end else begin
        exp_busy = 1;
      end
    end
    hist_c[cyc] = cur_c; hist_s[cyc] = cur_s; hist_id[cyc] = cur_id;
    chk("coef_done", int'(coef_done), exp_done, 0);
    chk("busy", int'(busy), exp_busy, 0);
    exp_v = (pq.size() > 0 && pq[0].cyc == cyc - 3) ? 1 : 0;
    chk("out_valid", int'(out_valid), exp_v, 0);
    if (exp_v == 1) begin
      p = pq.pop_front();
      tol = hist_id[p.cyc + 1] ? 0 : RTOL;
      chk("model_rx", int'(rx), rot_ref(p.x, p.y, hist_c[p.cyc + 1], hist_s[p.cyc + 1], 1'b1), tol);
      chk("model_ry", int'(ry), rot_ref(p.x, p.y, hist_c[p.cyc + 1], hist_s[p.cyc + 1], 1'b0), tol);
    end
  endtask

  task automatic send_pix(input int x, input int y);
    pix_valid = 1'b1; pix_x = CW'(x); pix_y = CW'(y);
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
  endtask

  typedef struct { int ang; int sc; int x; int y; int erx; int ery; int tx; int ty; } vec_t;
  vec_t vecs[$];

  initial begin
    int n, u2, pulses, first;
    // ang < 0 means "pulse reset" to get the exact identity coefficients.
    vecs.push_back('{-1,  128,   100,    50,   100,    50, 0, 0});
    vecs.push_back('{256, 128,   100,     0,     0,   100, 1, 1});
    vecs.push_back('{512, 128,   100,    50,  -100,   -50, 1, 1});
    vecs.push_back('{768, 128,   100,     0,     0,  -100, 1, 1});
    vecs.push_back('{128, 128,  1023,  1023,     0,  1023, 1, 0});
    vecs.push_back('{128, 128, -1024, -1024,     0, -1024, 1, 0});
    vecs.push_back('{512, 128, -1024,     0,  1023,     0, 1, 1});
`ifdef ROTATOR_SCALE_EN
    vecs.push_back('{0,    64,   100,    50,    50,    25, 1, 1});
`endif

    reset = 1'b1;
    tick();
    tick();
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_coef_done", int'(coef_done), 0, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    chk("reset_rx", int'(rx), 0, 0);
    chk("reset_ry", int'(ry), 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].ang < 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end else begin
        angle = 10'(vecs[i].ang);
`ifdef ROTATOR_SCALE_EN
        scale = 8'(vecs[i].sc);
`endif
        update = 1'b1; tick(); update = 1'b0;
        n = 1;
        while (!coef_done && n < 4 * DONE_LAT) begin tick(); n++; end
        chk($sformatf("vec%0d_done_latency", i), n, DONE_LAT, 0);
      end
      send_pix(vecs[i].x, vecs[i].y);
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1, 0);
      chk($sformatf("vec%0d_rx", i), int'(rx), vecs[i].erx, vecs[i].tx);
      chk($sformatf("vec%0d_ry", i), int'(ry), vecs[i].ery, vecs[i].ty);
      tick();
      tick();
      chk($sformatf("vec%0d_hold_rx", i), int'(rx), vecs[i].erx, vecs[i].tx);
      chk($sformatf("vec%0d_hold_ry", i), int'(ry), vecs[i].ery, vecs[i].ty);
    end

`ifdef ROTATOR_SCALE_EN
    scale = 8'd128;
`endif
    // Restart: second update four cycles after the first must yield exactly one commit.
    angle = 10'd256; update = 1'b1; tick(); update = 1'b0;
    repeat (3) tick();
    angle = 10'd0; update = 1'b1; u2 = cyc;
    pulses = 0; first = -1;
    repeat (DONE_LAT + 12) begin
      tick();
      update = 1'b0;
      if (coef_done) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    chk("restart_pulses", pulses, 1, 0);
    chk("restart_latency", first - u2, DONE_LAT, 0);
    send_pix(100, 50);
    chk("restart_rx", int'(rx), 100, 1);
    chk("restart_ry", int'(ry), 50, 1);

    // Reset during RUN with pixels in flight.
    angle = 10'd256; update = 1'b1; tick(); update = 1'b0;
    repeat (3) tick();
    pix_valid = 1'b1; pix_x = 11'sd100; pix_y = 11'sd50; tick();
    pix_x = 11'sd20; pix_y = 11'sd30; tick();
    pix_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_busy", int'(busy), 0, 0);
    chk("midreset_out_valid", int'(out_valid), 0, 0);
    chk("midreset_rx", int'(rx), 0, 0);
    repeat (DONE_LAT + 2) tick();
    send_pix(100, 50);
    chk("midreset_identity_rx", int'(rx), 100, 0);
    chk("midreset_identity_ry", int'(ry), 50, 0);

    // Random traffic: updates, restarts, mid-stream commits and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      update = ($urandom_range(0, 29) == 0);
      angle = 10'($urandom);
`ifdef ROTATOR_SCALE_EN
      scale = 8'($urandom);
`endif
      pix_valid = 1'($urandom_range(0, 1));
      pix_x = CW'($urandom);
      pix_y = CW'($urandom);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    update = 1'b0; pix_valid = 1'b0; reset = 1'b0;
    repeat (DONE_LAT + 5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
